// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch stage: PC owner, ROM address driver, valid/ready to decode
// Optional: IFETCH_MISALIGN_TRAP_EN turns misaligned redirects into a FAULT state instead of fetching.
module ifetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                IMEM_AW  = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [DATA_W-1:0] imem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              fetch_fault
);

  // 2'b11 is the FAULT state when the trap is built in, otherwise an illegal code.
  typedef enum logic [1:0] {
    S_ISSUE = 2'b00,
    S_WAIT  = 2'b01,
    S_VALID = 2'b10,
    S_FAULT = 2'b11
  } state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] pc, pc_d;
  logic              valid_d;
  logic [DATA_W-1:0] instr_d;
  logic [ADDR_W-1:0] opc_d;
  logic              fault_d;
  logic              fault_q;

  assign imem_addr = ADDR_W'(pc[IMEM_AW+1:2]);

  always_comb begin
    state_d = state;
    pc_d    = pc;
    valid_d = out_valid;
    instr_d = out_instr;
    opc_d   = out_pc;
    fault_d = fault_q;
    case (state)
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (imem_ready) begin
          instr_d = imem_data;
          opc_d   = pc;
          valid_d = 1'b1;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        if (out_ready) begin
          pc_d    = pc + ADDR_W'(4);
          valid_d = 1'b0;
          state_d = S_ISSUE;
        end
      end
      default: begin
`ifdef IFETCH_MISALIGN_TRAP_EN
        // Only a redirect leaves FAULT; acceptance just retires the NOP.
        if (out_ready) valid_d = 1'b0;
`else
        valid_d = 1'b0;
        state_d = S_ISSUE;
`endif
      end
    endcase

    // Redirect overrides everything, including a same-cycle ROM response.
    if (redirect_valid) begin
`ifdef IFETCH_MISALIGN_TRAP_EN
      pc_d = redirect_pc;
      if (redirect_pc[1:0] != 2'b00) begin
        state_d = S_FAULT;
        valid_d = 1'b1;
        instr_d = DATA_W'(32'h0000_0013);
        opc_d   = redirect_pc;
        fault_d = 1'b1;
      end else begin
        state_d = S_ISSUE;
        valid_d = 1'b0;
        fault_d = 1'b0;
      end
`else
      pc_d    = redirect_pc & ~ADDR_W'(3);
      state_d = S_ISSUE;
      valid_d = 1'b0;
      fault_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state     <= S_ISSUE;
      pc        <= RESET_PC;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
      fault_q   <= 1'b0;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      out_valid <= valid_d;
      out_instr <= instr_d;
      out_pc    <= opc_d;
      fault_q   <= fault_d;
    end
  end

`ifdef IFETCH_MISALIGN_TRAP_EN
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - scoreboard bench for ifetch_unit: directed sequence then random traffic
module tb_ifetch_unit;

  logic        iCLK;
  logic        iRST_n;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  logic [31:0] rom [256];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          hs_count = 0;
  bit          mon_en   = 1'b1;
  logic [31:0] exp_q [$];

  ifetch_unit dut (
    .iCLK          (iCLK),
    .iRST_n        (iRST_n),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_data     (imem_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .fetch_fault   (fetch_fault)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  assign imem_data = imem_ready ? rom[imem_addr[7:0]] : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples just before each rising edge, when next-edge inputs are settled.
  initial begin
    logic [31:0] front, hold_pc, hold_instr, nxt;
    bit          hold, hs;
    hold = 1'b0;
    forever begin
      @(negedge iCLK);
      #4;
      if (!iRST_n) begin
        exp_q = {32'h0};
        hold  = 1'b0;
        continue;
      end
      if (!mon_en) begin
        hold = 1'b0;
        if (redirect_valid) exp_q = {redirect_pc & ~32'h3};
        continue;
      end
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 32'd0, 32'd1);
        exp_q = {32'h0};
      end
      front = exp_q[0];
      chk("imem_addr", imem_addr, {24'h0, front[9:2]});
      if (hold) begin
        chk("hold_valid", {31'h0, out_valid}, 32'd1);
        chk("hold_pc", out_pc, hold_pc);
        chk("hold_instr", out_instr, hold_instr);
      end
      hs = out_valid && out_ready;
      if (hs) begin
        hs_count++;
        chk("out_pc", out_pc, front);
        chk("out_instr", out_instr, rom[front[9:2]]);
      end
      hold       = out_valid && !out_ready && !redirect_valid;
      hold_pc    = out_pc;
      hold_instr = out_instr;
      if (redirect_valid) begin
        exp_q = {redirect_pc & ~32'h3};
      end else if (hs) begin
        nxt = exp_q.pop_front() + 32'd4;
        exp_q.push_back(nxt);
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    iRST_n = 1'b0; imem_ready = 1'b1; out_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    repeat (2) @(negedge iCLK);
    chk("rst_valid", {31'h0, out_valid}, 32'd0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_fault", {31'h0, fetch_fault}, 32'd0);
    iRST_n = 1'b1;

    // Back-to-back: one instruction every three cycles.
    for (int k = 1; k <= 4; k++) begin
      @(negedge iCLK);
      chk("rate_valid", {31'h0, out_valid}, {31'h0, k == 2});
    end
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge iCLK);
      chk("stall_valid", {31'h0, out_valid}, 32'd1);
      chk("stall_pc", out_pc, 32'h4);
      chk("stall_instr", out_instr, rom[1]);
      chk("stall_addr", imem_addr, 32'h1);
    end
    out_ready = 1'b1;
    repeat (3) @(negedge iCLK);
    chk("pre_redir_valid", {31'h0, out_valid}, 32'd1);
    chk("pre_redir_pc", out_pc, 32'h8);
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    @(negedge iCLK);
    chk("redir_hs_addr", imem_addr, 32'h20);
    chk("redir_hs_valid", {31'h0, out_valid}, 32'd0);
    redirect_valid = 1'b0;
    @(negedge iCLK);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    @(negedge iCLK);
    chk("redir_wait_addr", imem_addr, 32'h10);
    chk("redir_wait_valid", {31'h0, out_valid}, 32'd0);
    redirect_valid = 1'b0;
    repeat (2) @(negedge iCLK);
    chk("redir_wait_pc", out_pc, 32'h40);
    imem_ready = 1'b0;
    repeat (2) @(negedge iCLK);
    #2 iRST_n = 1'b0;
    #1;
    chk("async_valid", {31'h0, out_valid}, 32'd0);
    chk("async_pc", out_pc, 32'h0);
    chk("async_instr", out_instr, 32'h0);
    chk("async_addr", imem_addr, 32'h0);
    @(negedge iCLK);
    iRST_n = 1'b1; imem_ready = 1'b1;

`ifdef IFETCH_MISALIGN_TRAP_EN
    repeat (3) @(negedge iCLK);
    mon_en = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h22;
    @(negedge iCLK);
    redirect_valid = 1'b0;
    chk("fault_flag", {31'h0, fetch_fault}, 32'd1);
    chk("fault_valid", {31'h0, out_valid}, 32'd1);
    chk("fault_instr", out_instr, 32'h13);
    chk("fault_pc", out_pc, 32'h22);
    out_ready = 1'b1;
    repeat (2) @(negedge iCLK);
    chk("fault_retired", {31'h0, out_valid}, 32'd0);
    chk("fault_sticky", {31'h0, fetch_fault}, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h24; mon_en = 1'b1;
    @(negedge iCLK);
    redirect_valid = 1'b0;
    chk("fault_clear", {31'h0, fetch_fault}, 32'd0);
    repeat (2) @(negedge iCLK);
    chk("fault_refetch_pc", out_pc, 32'h24);
`endif

    for (int c = 0; c < 4000; c++) begin
      @(negedge iCLK);
      if ($urandom_range(699) == 0) begin
        #2 iRST_n = 1'b0;
        @(negedge iCLK);
        iRST_n = 1'b1;
      end
      imem_ready     = ($urandom_range(2) != 0);
      out_ready      = $urandom_range(1);
      redirect_valid = ($urandom_range(11) == 0);
      case ($urandom_range(3))
        0: redirect_pc = $urandom;
        1: redirect_pc = 32'hFFFF_FFF0 + $urandom_range(15);
        2: redirect_pc = $urandom_range(1023);
        default: redirect_pc = out_pc;
      endcase
`ifdef IFETCH_MISALIGN_TRAP_EN
      redirect_pc = redirect_pc & ~32'h3;
`endif
    end
    redirect_valid = 1'b0;
    repeat (2) @(negedge iCLK);
    chk("handshake_count_min", {31'h0, hs_count > 100}, 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
